// File: rtl/demux_rr_sched.sv
// demux_rr_sched: round-robin burst scheduler driving a 1-to-4 demux select plus one-hot valids
// Ports: clk/rst (async, active-high); en_mask per-channel enable;
//   in_valid/in_data/in_ready input stream; sel = {a,b} demux select (== ptr);
//   out_data registered word; out_valid one-hot for sel; out_ready per-sink ready;
//   burst_done pulses on the fire that completes a burst.
module demux_rr_sched #(
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   en_mask,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic [1:0]   sel,
  output logic [W-1:0] out_data,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic         burst_done
);
  localparam int CW = BURST > 1 ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);
  typedef enum logic [1:0] {OFF, EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, nxt, low;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] data_q, data_d;
  logic fire, take, last, any_en;
  // nxt: first enabled channel after ptr in rotation, ptr itself if none; low: lowest enabled
  always_comb begin
    nxt = ptr_q;
    for (int k = 3; k >= 1; k--) if (en_mask[ptr_q + 2'(k)]) nxt = ptr_q + 2'(k);
    low = 2'd0;
    for (int k = 3; k >= 0; k--) if (en_mask[k]) low = 2'(k);
  end
  assign any_en     = |en_mask;
  assign fire       = (state_q == FULL) & out_ready[ptr_q];
  assign last       = cnt_q == LAST;
  assign in_ready   = any_en & ((state_q == EMPTY) | fire);
  assign take       = in_valid & in_ready;
  assign burst_done = fire & last;
  assign out_valid  = state_q == FULL ? 4'd1 << ptr_q : 4'd0;
  assign sel        = ptr_q;
  assign out_data   = data_q;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = take ? in_data : data_q;
    if (state_q == OFF) begin
      if (any_en) begin
        state_d = EMPTY;
        ptr_d   = low;
        cnt_d   = '0;
      end
    end else if (state_q == EMPTY) begin
      if (!any_en) state_d = OFF;
      else begin
        if (take) state_d = FULL;
        // an idle, disabled channel is skipped only between bursts
        if (!en_mask[ptr_q] && cnt_q == '0) ptr_d = nxt;
      end
    end else if (fire) begin
      cnt_d   = last ? '0 : CW'(cnt_q + 1'b1);
      ptr_d   = last ? nxt : ptr_q;
      state_d = take ? FULL : (any_en ? EMPTY : OFF);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OFF;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end
endmodule
